seg_mux_driver: RTL and testbench
=================================

Name: seg_mux_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for the Nexys4 8-digit display; generalises the single-digit 4-bit-to-7-segment decoder.
- Scans DIGITS hex digits across shared cathodes using a refresh prescaler, a digit-index counter and a per-slot anti-ghosting dead time.
- Loads new display values tear-free, applying them only at frame boundaries.
- Sits between the application datapath and the board's AN/SEG/DP pins.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 2..16.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 16, cycles at the start of each slot during which all anodes are inactive (dead time).
- ACTIVE_LOW, 1, 1 means AN, SEG and DP_OUT are driven active-low (Nexys4); 0 means active-high.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- EN  in  1  scan enable.
- LOAD  in  1  single-cycle strobe that captures VALUE/DP/BLANK.
- VALUE  in  4*DIGITS  hex nibbles; digit k is VALUE[4k+3:4k], digit 0 is rightmost.
- DP  in  DIGITS  per-digit decimal point request.
- BLANK  in  DIGITS  per-digit forced blank.
- AN  out  DIGITS  anode drive; one-hot when active.
- SEG  out  7  cathodes {g,f,e,d,c,b,a}.
- DP_OUT  out  1  decimal-point cathode.
- FRAME  out  1  one-cycle pulse per completed scan.

Behaviour:
- Interface: one clock, CLK. Reset RST_N is synchronous and active-low.
- Reset state (RST_N=0 at a CLK edge):
  - prescaler cnt=0, digit index idx=0.
  - pending and shadow registers are 0; pending flag is clear.
  - AN, SEG and DP_OUT are all inactive (all 1s when ACTIVE_LOW=1).
  - FRAME=0.
  - Reset mid-scan or mid-load discards the pending value.
- Prescaler:
  - While EN=1, cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, idx increments; DIGITS-1 wraps to 0.
- EN=0: cnt and idx hold, AN is forced inactive, FRAME=0. Scanning resumes from the held state when EN returns to 1.
- Load path:
  - LOAD=1 captures VALUE/DP/BLANK into the pending register and sets the pending flag. A later LOAD before the boundary overwrites it.
  - At frame boundary (cnt wraps while idx=DIGITS-1), shadow takes pending if the flag is set, then the flag clears.
  - If LOAD coincides with the boundary cycle, the incoming VALUE/DP/BLANK goes straight to shadow (bypass).
  - The displayed data never mixes two loads within one frame.
- Decode:
  - Hex 0-F maps to the standard glyphs (active-high): 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71.
  - ACTIVE_LOW=1 inverts SEG, AN and DP_OUT.
  - A digit with BLANK=1 drives SEG and DP_OUT inactive; its anode still follows the scan.
- Dead time: AN[idx] is active only while cnt >= BLANK_CYCLES. SEG/DP_OUT present the idx digit for the whole slot.
- Latency: all outputs are registered, one cycle after the (cnt, idx, shadow) state that produces them.
- FRAME is asserted on the cycle after the boundary, when the first slot-0 outputs become visible.
- Frame period = DIGITS*REFRESH_DIV cycles.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero nibble of shadow are blanked as if BLANK=1, unless that digit's DP=1. Digit 0 is always shown, so value 0 displays a single "0".
- Undefined: every digit shows its nibble, including leading zeros.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - the segment bit-index constants A..G;
  - the glyph constant for blank.
- One natural sub-module: hex_seg_decoder, combinational 4-bit nibble to 7-bit active-high glyph. The top module handles polarity.

Test Plan:
1. Reset: DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, RST_N=0 for 3 cycles -> AN=4'b1111, SEG=7'h7F, DP_OUT=1, FRAME=0.
2. Scan and frame: LOAD VALUE=16'h1A80, EN=1 -> after the boundary:
   - slots show SEG=7'h40 ("0", digit 0), 7'h00 ("8", digit 1), 7'h08 ("A", digit 2), 7'h79 ("1", digit 3);
   - AN steps 1110/1101/1011/0111, each inactive for its first cycle;
   - FRAME pulses every 16 cycles.
3. Tear-free load: LOAD 16'h2222 mid-frame at idx=1 -> digits 1-3 keep the old value until the next FRAME, then all show "2". LOAD in the exact boundary cycle takes effect immediately.
4. EN/BLANK: BLANK=4'b0100, DP=4'b0001 -> digit 2 SEG=7'h7F with AN still scanning; digit 0 DP_OUT=0. Dropping EN mid-slot -> AN=1111 with cnt/idx frozen; they resume on EN=1.
5. Reset mid-operation: pending LOAD then RST_N=0 one cycle before the boundary -> shadow=0, pending discarded, outputs inactive.
6. With SEG_LEADING_ZERO_BLANK_EN: VALUE=16'h0030 -> digits 3,2 blank, digit 1 "3", digit 0 "0". VALUE=0 -> only digit 0 shows "0".

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment driver: hex glyph table, segment bit
// positions and the blank glyph. Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Entry n is the glyph for hex digit n; the first element listed is entry 15.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_drive(input logic [6:0] glyph_hi, input logic active_low);
    return active_low ? ~glyph_hi : glyph_hi;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph {g,f,e,d,c,b,a}.
module hex_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed DIGITS-digit seven-segment driver with dead time and tear-free loads.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLANK,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  DP_OUT,
  output logic                  FRAME
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]    cnt_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_blank;
  logic                pend_flag;
  logic [4*DIGITS-1:0] shadow_val_p0;
  logic [DIGITS-1:0]   shadow_dp_p0;
  logic [DIGITS-1:0]   shadow_blank_p0;
  logic                wrap_p0;
  logic                bnd_p0;
  logic                frame_due;

  logic [3:0]          nib_p0;
  logic                dp_sel_p0;
  logic                blk_sel_p0;
  logic                lz_p0;
  logic                blank_p0;
  logic [6:0]          glyph_p0;
  logic [6:0]          seg_hi_p0;
  logic                dp_hi_p0;
  logic [DIGITS-1:0]   an_hi_p0;

  logic [DIGITS-1:0]   an_p1;
  logic [6:0]          seg_p1;
  logic                dp_p1;
  logic                frame_p1;

  // ---- stage p0: scan state, load path and digit selection ----
  assign wrap_p0 = EN && (cnt_p0 == CNT_LAST);
  assign bnd_p0  = wrap_p0 && (idx_p0 == IDX_LAST);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (EN) begin
      if (wrap_p0) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Shadow only changes on the frame boundary, so one frame never mixes two loads.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_val        <= '0;
      pend_dp         <= '0;
      pend_blank      <= '0;
      pend_flag       <= 1'b0;
      shadow_val_p0   <= '0;
      shadow_dp_p0    <= '0;
      shadow_blank_p0 <= '0;
    end else if (bnd_p0) begin
      if (LOAD) begin
        shadow_val_p0   <= VALUE;
        shadow_dp_p0    <= DP;
        shadow_blank_p0 <= BLANK;
      end else if (pend_flag) begin
        shadow_val_p0   <= pend_val;
        shadow_dp_p0    <= pend_dp;
        shadow_blank_p0 <= pend_blank;
      end
      pend_flag <= 1'b0;
    end else if (LOAD) begin
      pend_val   <= VALUE;
      pend_dp    <= DP;
      pend_blank <= BLANK;
      pend_flag  <= 1'b1;
    end
  end

  always_comb begin
    nib_p0     = 4'h0;
    dp_sel_p0  = 1'b0;
    blk_sel_p0 = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_p0 == IDX_W'(k)) begin
        nib_p0     = shadow_val_p0[4*k +: 4];
        dp_sel_p0  = shadow_dp_p0[k];
        blk_sel_p0 = shadow_blank_p0[k];
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_p0;

  always_comb begin
    msd_p0 = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (shadow_val_p0[4*k +: 4] != 4'h0) msd_p0 = IDX_W'(k);
    end
  end

  // A lit decimal point keeps an otherwise leading zero visible.
  assign lz_p0 = (idx_p0 > msd_p0) && !dp_sel_p0;
`else
  assign lz_p0 = 1'b0;
`endif

  hex_seg_decoder u_dec (
    .nibble (nib_p0),
    .glyph  (glyph_p0)
  );

  assign blank_p0  = blk_sel_p0 | lz_p0;
  assign seg_hi_p0 = blank_p0 ? GLYPH_BLANK : glyph_p0;
  assign dp_hi_p0  = !blank_p0 && dp_sel_p0;
  assign an_hi_p0  = (EN && (cnt_p0 >= CNT_LIT)) ? (DIGITS'(1) << idx_p0) : '0;

  // ---- stage p1: registered pin drive ----
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      an_p1     <= {DIGITS{POL}};
      seg_p1    <= {7{POL}};
      dp_p1     <= POL;
      frame_p1  <= 1'b0;
      frame_due <= 1'b0;
    end else begin
      an_p1    <= an_hi_p0 ^ {DIGITS{POL}};
      seg_p1   <= seg_drive(seg_hi_p0, POL);
      dp_p1    <= dp_hi_p0 ^ POL;
      // FRAME lines up with the first registered slot-0 outputs of the new frame.
      frame_p1 <= EN && frame_due;
      if (EN) frame_due <= bnd_p0;
    end
  end

  assign AN     = an_p1;
  assign SEG    = seg_p1;
  assign DP_OUT = dp_p1;
  assign FRAME  = frame_p1;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Self-checking bench for seg_mux_driver (4 digits, 4-cycle slots, 1-cycle dead time).
module tb_seg_mux_driver;

  localparam int ND   = 4;
  localparam int RDIV = 4;
  localparam int BLK  = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE = 16'h0;
  logic [3:0]  DP = 4'h0;
  logic [3:0]  BLANK = 4'h0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP_OUT;
  logic        FRAME;

  int n_tests = 0;
  int n_fail  = 0;

  seg_mux_driver #(
    .DIGITS(ND), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD(LOAD), .VALUE(VALUE),
    .DP(DP), .BLANK(BLANK), .AN(AN), .SEG(SEG), .DP_OUT(DP_OUT), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Scoreboard: cycle model pushes the expected pins at each edge; compared half a cycle later.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } out_t;

  out_t        sb_q[$];
  out_t        e_o;
  int          m_cnt = 0, m_idx = 0, m_top = 0;
  logic [15:0] m_val = 0, p_val = 0;
  logic [3:0]  m_dp = 0, m_bl = 0, p_dp = 0, p_bl = 0, m_nib;
  bit          p_flag = 0, m_fr = 0, m_blank = 0, m_bnd = 0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      e_o = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fr: 1'b0};
      m_cnt = 0; m_idx = 0; m_val = 0; m_dp = 0; m_bl = 0;
      p_val = 0; p_dp = 0; p_bl = 0; p_flag = 0; m_fr = 0;
    end else begin
      m_nib = 4'((m_val >> (4 * m_idx)) & 16'hF);
      m_top = 0;
      for (int k = 0; k < ND; k++)
        if (((m_val >> (4 * k)) & 16'hF) != 0) m_top = k;
      m_blank = m_bl[m_idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (m_idx > m_top && !m_dp[m_idx]) m_blank = 1;
`endif
      e_o.seg = m_blank ? 7'h7F : ~glyph(m_nib);
      e_o.dp  = m_blank ? 1'b1 : ~m_dp[m_idx];
      e_o.an  = (EN && m_cnt >= BLK) ? ~(4'b0001 << m_idx) : 4'hF;
      e_o.fr  = EN && m_fr;
      m_bnd = EN && m_cnt == RDIV - 1 && m_idx == ND - 1;
      if (m_bnd) begin
        if (LOAD) begin m_val = VALUE; m_dp = DP; m_bl = BLANK; end
        else if (p_flag) begin m_val = p_val; m_dp = p_dp; m_bl = p_bl; end
        p_flag = 0;
      end else if (LOAD) begin
        p_val = VALUE; p_dp = DP; p_bl = BLANK; p_flag = 1;
      end
      if (EN) begin
        m_fr = m_bnd;
        if (m_cnt == RDIV - 1) begin
          m_cnt = 0;
          m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    sb_q.push_back(e_o);
  end

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      out_t x;
      x = sb_q.pop_front();
      chk("sb_an", 32'(AN), 32'(x.an));
      chk("sb_seg", 32'(SEG), 32'(x.seg));
      chk("sb_dp", 32'(DP_OUT), 32'(x.dp));
      chk("sb_frame", 32'(FRAME), 32'(x.fr));
    end
  end

  task automatic wait_frame(input int max_cyc);
    int n;
    n = 0;
    while (FRAME !== 1'b1 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    if (FRAME !== 1'b1) chk("frame_wait", 32'(FRAME), 32'd1);
  endtask

  // Called at the negedge where FRAME is visible; walks one 16-cycle frame and
  // optionally issues a LOAD at offset ld_j. segs/dpo are {slot3..slot0} pin values.
  task automatic frame_pass(input logic [3:0][6:0] segs, input logic [3:0] dpo,
                            input int ld_j, input logic [15:0] ld_val,
                            input logic [3:0] ld_dp, input logic [3:0] ld_bl);
    logic [3:0] an_e;
    int fr_seen;
    fr_seen = 0;
    for (int j = 0; j < 16; j++) begin
      int s;
      s = j / 4;
      if (j == ld_j) begin
        VALUE = ld_val; DP = ld_dp; BLANK = ld_bl; LOAD = 1'b1;
      end else begin
        LOAD = 1'b0;
      end
      if (j % 4 == 0) chk("an_dead", 32'(AN), 32'hF);
      if (j % 4 == 2) begin
        an_e = ~(4'b0001 << s);
        chk("an_slot", 32'(AN), 32'(an_e));
        chk("seg_slot", 32'(SEG), 32'(segs[s]));
        chk("dp_slot", 32'(DP_OUT), 32'(dpo[s]));
      end
      if (j > 0 && FRAME === 1'b1) fr_seen++;
      @(negedge CLK);
    end
    LOAD = 1'b0;
    chk("frame_gap", 32'(fr_seen), 32'd0);
    chk("frame_16", 32'(FRAME), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge CLK);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(SEG), 32'h7F);
    chk("rst_dp", 32'(DP_OUT), 32'd1);
    chk("rst_frame", 32'(FRAME), 32'd0);
    RST_N = 1'b1;

    // Scan and frame timing, then mid-frame load that must wait for the boundary
    VALUE = 16'h1A80; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0; EN = 1'b1;
    wait_frame(64);
    frame_pass({7'h79, 7'h08, 7'h00, 7'h40}, 4'hF, 5, 16'h2222, 4'h0, 4'h0);
    // Load in the boundary cycle goes straight to the next frame
    frame_pass({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 14, 16'h8421, 4'h0, 4'h0);
    // Load just after the boundary is held a whole frame
    frame_pass({7'h00, 7'h19, 7'h24, 7'h79}, 4'hF, 15, 16'hFFFF, 4'h0, 4'h0);
    frame_pass({7'h00, 7'h19, 7'h24, 7'h79}, 4'hF, -1, 16'h0, 4'h0, 4'h0);
    frame_pass({7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'hF, 14, 16'h1A80, 4'b0001, 4'b0100);
    // Forced blank on digit 2, decimal point on digit 0
    frame_pass({7'h79, 7'h7F, 7'h00, 7'h40}, 4'b1110, -1, 16'h0, 4'h0, 4'h0);

    // Drop EN mid-slot and resume
    repeat (5) @(negedge CLK);
    chk("en_pre_an", 32'(AN), 32'b1101);
    EN = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("en_off_an", 32'(AN), 32'hF);
      chk("en_off_frame", 32'(FRAME), 32'd0);
    end
    EN = 1'b1;
    @(negedge CLK);
    chk("en_resume_an", 32'(AN), 32'b1101);
    repeat (2) @(negedge CLK);
    chk("en_resume_dead", 32'(AN), 32'hF);
    @(negedge CLK);
    chk("en_resume_next", 32'(AN), 32'b1011);

    // Reset one cycle before the boundary with a load pending
    wait_frame(64);
    for (int j = 0; j < 15; j++) begin
      LOAD = (j == 3);
      if (j == 3) begin VALUE = 16'h5555; DP = 4'h0; BLANK = 4'h0; end
      if (j == 13) RST_N = 1'b0;
      if (j == 14) begin
        chk("mid_rst_an", 32'(AN), 32'hF);
        chk("mid_rst_seg", 32'(SEG), 32'h7F);
        chk("mid_rst_dp", 32'(DP_OUT), 32'd1);
        RST_N = 1'b1;
      end
      @(negedge CLK);
    end
    LOAD = 1'b0;
    chk("post_rst_seg", 32'(SEG), 32'h40);
    chk("post_rst_frame", 32'(FRAME), 32'd0);
    wait_frame(64);

    // Zero value, leading-zero handling, decimal point keeps a leading zero lit
`ifdef SEG_LEADING_ZERO_BLANK_EN
    frame_pass({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 14, 16'h0030, 4'h0, 4'h0);
    frame_pass({7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF, 14, 16'h0030, 4'b1000, 4'h0);
    frame_pass({7'h40, 7'h7F, 7'h30, 7'h40}, 4'b0111, -1, 16'h0, 4'h0, 4'h0);
`else
    frame_pass({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 14, 16'h0030, 4'h0, 4'h0);
    frame_pass({7'h40, 7'h40, 7'h30, 7'h40}, 4'hF, 14, 16'h0030, 4'b1000, 4'h0);
    frame_pass({7'h40, 7'h40, 7'h30, 7'h40}, 4'b0111, -1, 16'h0, 4'h0, 4'h0);
`endif

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
